// File: rtl/shift_ctrl.sv
// -----------------------------------------------------------------------------
// shift_ctrl
//   Sequencer/decoder for the barrel_shifter datapath. Accepts an ARM
//   data-processing shift request and produces a registered control word.
//   The word holds one-hot two-stage rotate selects, mask controls and a
//   carry-out source select. Immediate-amount shifts produce the word one
//   cycle after acceptance. Register-amount shifts take one extra cycle so
//   that Rs can be read on the shared register port.
//
// Ports
//   clk, reset, flush     : clock, sync active-high reset, sync pipeline flush
//   req_valid / req_ready : request handshake
//   sh_type               : 00 LSL, 01 LSR, 10 ASR, 11 ROR
//   reg_form              : 1 = amount from rs_amt, 0 = amount from imm_amt
//   imm_amt               : immediate shift amount
//   rs_amt                : Rs[7:0], sampled the cycle after a reg_form accept
//   out_valid / out_ready : control word handshake towards the shifter
//   shctl_5, shctl_8      : one-hot first/second stage rotate selects
//   shamt, longshift      : mask amount, mask-all for amounts >= 32
//   left, shift, arith    : left-shift mask, apply mask, sign fill
//   rrx_sel               : shifter rrx_in = C flag instead of a[0]
//   carry_sel             : 000 keep, 001 a0, 010 a31, 011 rot0, 100 rot31,
//                           101 zero
// -----------------------------------------------------------------------------
module shift_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] sh_type,
  input  logic       reg_form,
  input  logic [4:0] imm_amt,
  input  logic [7:0] rs_amt,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] shctl_5,
  output logic [7:0] shctl_8,
  output logic [4:0] shamt,
  output logic       longshift,
  output logic       left,
  output logic       shift,
  output logic       arith,
  output logic       rrx_sel,
  output logic [2:0] carry_sel
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_RS = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam logic [2:0] CS_KEEP  = 3'b000;
  localparam logic [2:0] CS_A0    = 3'b001;
  localparam logic [2:0] CS_A31   = 3'b010;
  localparam logic [2:0] CS_ROT0  = 3'b011;
  localparam logic [2:0] CS_ROT31 = 3'b100;
  localparam logic [2:0] CS_ZERO  = 3'b101;

  typedef struct packed {
    logic [4:0] shctl5;
    logic [7:0] shctl8;
    logic [4:0] shamt;
    logic       longshift;
    logic       left;
    logic       shift;
    logic       arith;
    logic       rrxSel;
    logic [2:0] carrySel;
  } ctlWord_t;

  // Idle word: rotate by zero (both stages select ROR0), no masking.
  localparam ctlWord_t IDLE_CTL = ctlWord_t'({5'b00001, 8'b00000001, 13'b0});

  // Decodes a shift type and effective amount n into a control word.
  // Left shifts become a right rotate by 32-n, split as stage1 = ~n[1:0]+1
  // (range 1..4, hence the fifth stage-1 select) and stage2 = 4*~n[4:2].
  // Amounts >= 32 only change mask/carry classification; rotation uses n[4:0].
  function automatic ctlWord_t decodeShift(input logic [1:0] t,
                                           input logic [7:0] n,
                                           input logic       rrx);
    ctlWord_t   c;
    logic [2:0] s1;
    logic [2:0] s2;
    c = IDLE_CTL;
    if (t == SH_LSL) begin
      s1 = {1'b0, ~n[1:0]} + 3'd1;
      s2 = ~n[4:2];
    end else begin
      s1 = {1'b0, n[1:0]};
      s2 = n[4:2];
    end
    c.shctl5 = 5'b00001 << s1;
    c.shctl8 = 8'b00000001 << s2;
    c.shamt  = n[4:0];
    if (rrx) begin
      c.shctl5   = 5'b00010;
      c.shctl8   = 8'b00000001;
      c.shamt    = 5'd0;
      c.rrxSel   = 1'b1;
      c.carrySel = CS_A0;
    end else if (n == 8'd0) begin
      c.carrySel = CS_KEEP;
    end else begin
      case (t)
        SH_LSL: begin
          c.left  = 1'b1;
          c.shift = 1'b1;
          if (n < 8'd32) begin
            c.carrySel = CS_ROT0;
          end else begin
            c.longshift = 1'b1;
            c.carrySel  = (n == 8'd32) ? CS_A0 : CS_ZERO;
          end
        end
        SH_LSR: begin
          c.shift = 1'b1;
          if (n < 8'd32) begin
            c.carrySel = CS_ROT31;
          end else begin
            c.longshift = 1'b1;
            c.carrySel  = (n == 8'd32) ? CS_A31 : CS_ZERO;
          end
        end
        SH_ASR: begin
          c.shift = 1'b1;
          c.arith = 1'b1;
          if (n < 8'd32) begin
            c.carrySel = CS_ROT31;
          end else begin
            c.longshift = 1'b1;
            c.carrySel  = CS_A31;
          end
        end
        default: begin
          // ROR by a nonzero multiple of 32 rotates by zero but still
          // updates carry from bit 31.
          c.carrySel = (n[4:0] != 5'd0) ? CS_ROT31 : CS_A31;
        end
      endcase
    end
    return c;
  endfunction

  logic [1:0] state_q, state_d;
  logic [1:0] shType_q, shType_d;
  logic       valid_q, valid_d;
  ctlWord_t   ctl_q, ctl_d;

  logic [7:0] immN;
  logic       immRrx;
  ctlWord_t   immCtl;
  ctlWord_t   rsCtl;
  logic       accept;

  // Immediate encoding quirks: LSR/ASR #0 mean #32, ROR #0 means RRX.
  always_comb begin
    immN   = {3'b000, imm_amt};
    immRrx = 1'b0;
    if (imm_amt == 5'd0) begin
      if (sh_type == SH_LSR || sh_type == SH_ASR) immN = 8'd32;
      if (sh_type == SH_ROR) immRrx = 1'b1;
    end
  end

  assign immCtl = decodeShift(sh_type, immN, immRrx);
  assign rsCtl  = decodeShift(shType_q, rs_amt, 1'b0);

  // A new request can only be taken when the output slot is free or is
  // being drained this cycle.
  always_comb begin
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_HOLD: req_ready = out_ready;
      default: req_ready = 1'b0;
    endcase
  end

  assign accept = req_valid & req_ready;

  // Next-state: immediate requests load the word directly, register
  // requests park the shift type and wait one cycle for rs_amt.
  always_comb begin
    state_d  = state_q;
    shType_d = shType_q;
    valid_d  = valid_q;
    ctl_d    = ctl_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (reg_form) begin
            shType_d = sh_type;
            state_d  = ST_WAIT_RS;
          end else begin
            ctl_d   = immCtl;
            valid_d = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_WAIT_RS: begin
        ctl_d   = rsCtl;
        valid_d = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          if (accept && !reg_form) begin
            ctl_d = immCtl;
          end else if (accept) begin
            shType_d = sh_type;
            ctl_d    = IDLE_CTL;
            valid_d  = 1'b0;
            state_d  = ST_WAIT_RS;
          end else begin
            ctl_d   = IDLE_CTL;
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        ctl_d   = IDLE_CTL;
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; flush behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q  <= ST_IDLE;
      shType_q <= SH_LSL;
      valid_q  <= 1'b0;
      ctl_q    <= IDLE_CTL;
    end else begin
      state_q  <= state_d;
      shType_q <= shType_d;
      valid_q  <= valid_d;
      ctl_q    <= ctl_d;
    end
  end

  assign out_valid = valid_q;
  assign shctl_5   = ctl_q.shctl5;
  assign shctl_8   = ctl_q.shctl8;
  assign shamt     = ctl_q.shamt;
  assign longshift = ctl_q.longshift;
  assign left      = ctl_q.left;
  assign shift     = ctl_q.shift;
  assign arith     = ctl_q.arith;
  assign rrx_sel   = ctl_q.rrxSel;
  assign carry_sel = ctl_q.carrySel;

endmodule
